apb_uart_arbiter: RTL and testbench

Two-port APB master that shares the single APB slave port of the UART (PADDR/PWDATA/PRDATA/PWRITE/PSEL/PENABLE/PREADY/PSLVERR) between two requesters, e.g. a configuration sequencer and a data-path/driver engine. It accepts one request at a time and arbitrates round-robin. It runs the APB IDLE/SETUP/ACCESS protocol, including PREADY wait states and a wait-state timeout. It returns read data and error status to the granted requester.

---
 rtl/apb_uart_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_uart_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_arbiter.sv
// Two-requester APB master in front of a single UART slave port.
// Round-robin arbitration, IDLE/SETUP/ACCESS sequencing, and a PREADY wait-state timeout.
module apb_uart_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [1:0]            rq_valid,
  input  logic [1:0]            rq_write,
  input  logic [2*ADDR_W-1:0]   rq_addr,
  input  logic [2*DATA_W-1:0]   rq_wdata,
  output logic [1:0]            rq_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                grant;
  logic                last_grant;
  logic                accept;
  logic                done;
  logic                abort;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accept is gated by PRESETn so rq_ready stays low while reset is held.
  always_comb begin
    state_nxt = state;
    grant     = last_grant;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (PRESETn && (rq_valid != 2'b00)) begin
          accept    = 1'b1;
          grant     = (rq_valid == 2'b11) ? ~last_grant : rq_valid[1];
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rq_ready  = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign sel_write = grant ? rq_write[1] : rq_write[0];
  assign sel_addr  = grant ? rq_addr[2*ADDR_W-1:ADDR_W]  : rq_addr[ADDR_W-1:0];
  assign sel_wdata = grant ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];

  // last_grant doubles as the owner of the transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      if (accept) begin
        last_grant <= grant;
        PSEL       <= 1'b1;
        PENABLE    <= 1'b0;
        PWRITE     <= sel_write;
        PADDR      <= sel_addr;
        PWDATA     <= sel_write ? sel_wdata : '0;
      end
      if (state == SETUP) begin
        PENABLE  <= 1'b1;
        wait_cnt <= '0;
      end
      if ((state == ACCESS) && !PREADY && !abort) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (done) begin
        PSEL      <= 1'b0;
        PENABLE   <= 1'b0;
        rsp_valid <= last_grant ? 2'b10 : 2'b01;
        rsp_err   <= PSLVERR;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end
      if (abort) begin
        PSEL      <= 1'b0;
        PENABLE   <= 1'b0;
        rsp_valid <= last_grant ? 2'b10 : 2'b01;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Bench for apb_uart_arbiter: directed protocol scenarios plus a randomized
// run against a transaction-level model of arbitration, latency and responses.
module tb_apb_uart_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [1:0]      rq_valid;
  logic [1:0]      rq_write;
  logic [2*AW-1:0] rq_addr;
  logic [2*DW-1:0] rq_wdata;
  logic [1:0]      rq_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_uart_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic test_reset();
    PRESETn = 1'b0; rq_valid = 2'b11; rq_write = 2'b11;
    rq_addr = {32'h44, 32'h40}; rq_wdata = '1;
    PREADY = 1'b1; PRDATA = '1; PSLVERR = 1'b1;
    repeat (2) @(negedge PCLK);
    #1;
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", {PSEL, PENABLE, PWRITE}); end
    checks++; if (PADDR !== '0) begin errors++; $display("FAIL rst_paddr got %h exp 0", PADDR); end
    checks++; if (PWDATA !== '0) begin errors++; $display("FAIL rst_pwdata got %h exp 0", PWDATA); end
    checks++; if (rq_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", rq_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rspv got %b exp 00", rsp_valid); end
    checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL rst_rsp got err %b data %h exp 0", rsp_err, rsp_rdata); end
    rq_valid = 2'b00; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_single_write();
    @(negedge PCLK);
    rq_valid = 2'b01; rq_write = 2'b01; rq_addr[31:0] = 32'h0C; rq_wdata[31:0] = 32'h83;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hDEAD_BEEF;
    #1;
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got %b exp 01", rq_ready); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin errors++; $display("FAIL wr_setup got %b exp 10", {PSEL, PENABLE}); end
    checks++; if (rq_ready !== 2'b00) begin errors++; $display("FAIL wr_busy_ready got %b exp 00", rq_ready); end
    rq_valid = 2'b00;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b111) begin errors++; $display("FAIL wr_access got %b exp 111", {PSEL, PENABLE, PWRITE}); end
    checks++; if (PADDR !== 32'h0C) begin errors++; $display("FAIL wr_paddr got %h exp c", PADDR); end
    checks++; if (PWDATA !== 32'h83) begin errors++; $display("FAIL wr_pwdata got %h exp 83", PWDATA); end
    @(negedge PCLK);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rspv got %b exp 01", rsp_valid); end
    checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL wr_rsp got err %b data %h exp 0", rsp_err, rsp_rdata); end
    checks++; if ({PSEL, PENABLE} !== 2'b00) begin errors++; $display("FAIL wr_release got %b exp 00", {PSEL, PENABLE}); end
    @(negedge PCLK);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_pulse got %b exp 00", rsp_valid); end
    PREADY = 1'b0;
  endtask

  task automatic test_read_wait();
    int acc;
    @(negedge PCLK);
    rq_valid = 2'b10; rq_write = 2'b00; rq_addr[63:32] = 32'h14; rq_wdata[63:32] = 32'hFFFF_FFFF;
    PREADY = 1'b0; PRDATA = 32'h5A;
    #1;
    checks++; if (rq_ready !== 2'b10) begin errors++; $display("FAIL rd_ready got %b exp 10", rq_ready); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin errors++; $display("FAIL rd_setup got %b exp 10", {PSEL, PENABLE}); end
    rq_valid = 2'b00;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (PENABLE !== 1'b1) break;
      acc++;
      checks++; if ({PSEL, PWRITE, PADDR, PWDATA} !== {2'b10, 32'h14, 32'h0}) begin
        errors++; $display("FAIL rd_access got sel/wr %b addr %h wdata %h exp 10 14 0", {PSEL, PWRITE}, PADDR, PWDATA);
      end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_rsp got %b exp 00", rsp_valid); end
      PREADY = (acc == 4);
      PRDATA = (acc == 4) ? 32'h60 : 32'h5A;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL rd_access_len got %0d exp 4", acc); end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_rspv got %b exp 10", rsp_valid); end
    checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'h60}) begin errors++; $display("FAIL rd_rsp got err %b data %h exp 0 60", rsp_err, rsp_rdata); end
    PREADY = 1'b0;
  endtask

  task automatic test_arbitration();
    int ng;
    int last_c;
    logic [1:0] exp;
    @(negedge PCLK);
    PRESETn = 1'b0; rq_valid = 2'b00;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rq_valid = 2'b11; rq_write = 2'b11; rq_addr = {32'h200, 32'h100}; rq_wdata = {32'h22, 32'h11};
    PREADY = 1'b1; PSLVERR = 1'b0;
    ng = 0; last_c = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge PCLK);
      #1;
      checks++; if (rq_ready === 2'b11 || rsp_valid === 2'b11) begin
        errors++; $display("FAIL arb_onehot got ready %b rsp %b exp at most one bit", rq_ready, rsp_valid);
      end
      if (rq_ready !== 2'b00) begin
        exp = (ng % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (rq_ready !== exp) begin errors++; $display("FAIL arb_order grant %0d got %b exp %b", ng, rq_ready, exp); end
        if (ng > 0) begin
          checks++; if (c - last_c != 3) begin errors++; $display("FAIL arb_spacing got %0d exp 3", c - last_c); end
        end
        last_c = c;
        ng++;
        if (ng == 4) break;
      end
    end
    checks++; if (ng != 4) begin errors++; $display("FAIL arb_count got %0d exp 4", ng); end
    @(negedge PCLK);
    rq_valid = 2'b00;
    repeat (3) @(negedge PCLK);
    PREADY = 1'b0;
  endtask

  task automatic test_slave_error();
    @(negedge PCLK);
    rq_valid = 2'b01; rq_write = 2'b00; rq_addr[31:0] = 32'h20;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hA5A5_1234;
    #1;
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL err_ready got %b exp 01", rq_ready); end
    @(negedge PCLK);
    rq_valid = 2'b00;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL err_access got %b exp 11", {PSEL, PENABLE}); end
    @(negedge PCLK);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL err_rspv got %b exp 01", rsp_valid); end
    checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'hA5A5_1234}) begin errors++; $display("FAIL err_rsp got err %b data %h exp 1 a5a51234", rsp_err, rsp_rdata); end
    PSLVERR = 1'b0; PREADY = 1'b0;
  endtask

  task automatic test_timeout();
    int acc;
    @(negedge PCLK);
    rq_valid = 2'b10; rq_write = 2'b00; rq_addr[63:32] = 32'h30;
    PREADY = 1'b0; PRDATA = 32'hBEEF; PSLVERR = 1'b0;
    #1;
    checks++; if (rq_ready !== 2'b10) begin errors++; $display("FAIL to_ready got %b exp 10", rq_ready); end
    @(negedge PCLK);
    rq_valid = 2'b00;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (PENABLE !== 1'b1) break;
      acc++;
    end
    checks++; if (acc != TO) begin errors++; $display("FAIL to_access_len got %0d exp %0d", acc, TO); end
    checks++; if (PSEL !== 1'b0) begin errors++; $display("FAIL to_psel got %b exp 0", PSEL); end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL to_rspv got %b exp 10", rsp_valid); end
    checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_rsp got err %b data %h exp 1 0", rsp_err, rsp_rdata); end
    rq_valid = 2'b01; rq_write = 2'b01; rq_addr[31:0] = 32'h34; rq_wdata[31:0] = 32'h55; PREADY = 1'b1;
    #1;
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL to_next_ready got %b exp 01", rq_ready); end
    @(negedge PCLK);
    rq_valid = 2'b00;
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin errors++; $display("FAIL to_next_setup got %b exp 10", {PSEL, PENABLE}); end
    @(negedge PCLK);
    checks++; if ({PADDR, PWDATA} !== {32'h34, 32'h55}) begin errors++; $display("FAIL to_next_apb got %h %h exp 34 55", PADDR, PWDATA); end
    @(negedge PCLK);
    checks++; if ({rsp_valid, rsp_err} !== 3'b010) begin errors++; $display("FAIL to_next_rsp got %b exp 010", {rsp_valid, rsp_err}); end
    PREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK);
    rq_valid = 2'b01; rq_write = 2'b01; rq_addr[31:0] = 32'h40; rq_wdata[31:0] = 32'h66; PREADY = 1'b0;
    #1;
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL rm_ready got %b exp 01", rq_ready); end
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL rm_access got %b exp 11", {PSEL, PENABLE}); end
    #2;
    PRESETn = 1'b0;
    #1;
    checks++; if ({PSEL, PENABLE, rq_ready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL rm_async got sel/en %b ready %b rsp %b exp all 0", {PSEL, PENABLE}, rq_ready, rsp_valid);
    end
    @(negedge PCLK);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_in_reset_rsp got %b exp 00", rsp_valid); end
    PRESETn = 1'b1; PREADY = 1'b1;
    #1;
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL rm_reaccept got %b exp 01", rq_ready); end
    @(negedge PCLK);
    rq_valid = 2'b00;
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 4'b1000) begin errors++; $display("FAIL rm_setup got %b exp 1000", {PSEL, PENABLE, rsp_valid}); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b11, 32'h40, 32'h66}) begin
      errors++; $display("FAIL rm_access2 got %b %h %h exp 11 40 66", {PSEL, PENABLE}, PADDR, PWDATA);
    end
    @(negedge PCLK);
    checks++; if ({rsp_valid, rsp_err} !== 3'b010) begin errors++; $display("FAIL rm_rsp got %b exp 010", {rsp_valid, rsp_err}); end
    PREADY = 1'b0;
  endtask

  // Transaction-level model: a grant owns the bus from acceptance until its response,
  // whose cycle follows from the slave's wait count and the timeout bound.
  task automatic test_random(input int ncyc);
    logic [1:0]  pend;
    logic [1:0]  outst;
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    logic        p_wr [2];
    bit          busy;
    int          g_c, done_c, m_w, k;
    logic        owner, mlast;
    logic [31:0] m_addr, m_wd, m_rd, exp_rd;
    logic        m_wr, m_se, exp_err;
    logic [1:0]  exp_rdy;
    pend = 2'b00; outst = 2'b00; busy = 1'b0; mlast = 1'b1; owner = 1'b0;
    g_c = 0; done_c = 0; m_w = 0; k = 0;
    m_addr = '0; m_wd = '0; m_rd = '0; exp_rd = '0; m_wr = 1'b0; m_se = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < 2; i++) begin p_addr[i] = '0; p_wd[i] = '0; p_wr[i] = 1'b0; end
    @(negedge PCLK);
    PRESETn = 1'b0; rq_valid = 2'b00;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge PCLK);
      if (busy && c == done_c) begin
        checks++; if (rsp_valid !== (owner ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_rspv c%0d got %b exp owner %b", c, rsp_valid, owner); end
        checks++; if ({rsp_err, rsp_rdata} !== {exp_err, exp_rd}) begin
          errors++; $display("FAIL rnd_rsp c%0d got err %b data %h exp %b %h", c, rsp_err, rsp_rdata, exp_err, exp_rd);
        end
        busy = 1'b0;
        outst[owner] = 1'b0;
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rnd_spurious_rsp c%0d got %b exp 00", c, rsp_valid); end
      end
      if (busy) begin
        checks++; if ({PSEL, PENABLE} !== {1'b1, (c >= g_c + 2)}) begin
          errors++; $display("FAIL rnd_phase c%0d got %b exp %b", c, {PSEL, PENABLE}, {1'b1, (c >= g_c + 2)});
        end
        checks++; if ({PWRITE, PADDR, PWDATA} !== {m_wr, m_addr, (m_wr ? m_wd : 32'h0)}) begin
          errors++; $display("FAIL rnd_apb c%0d got %b %h %h exp %b %h %h", c, PWRITE, PADDR, PWDATA, m_wr, m_addr, m_wr ? m_wd : 32'h0);
        end
      end else begin
        checks++; if ({PSEL, PENABLE} !== 2'b00) begin errors++; $display("FAIL rnd_idle_bus c%0d got %b exp 00", c, {PSEL, PENABLE}); end
      end
      if (busy && c >= g_c + 2) begin
        k = c - g_c - 2;
        PREADY  = (k == m_w);
        PRDATA  = (k == m_w) ? m_rd : $urandom;
        PSLVERR = (k == m_w) ? m_se : 1'($urandom_range(0, 1));
      end else begin
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          p_wr[i] = 1'($urandom_range(0, 1)); p_addr[i] = $urandom; p_wd[i] = $urandom;
          if (!outst[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
        end
      end
      rq_valid = pend;
      rq_write = {p_wr[1], p_wr[0]};
      rq_addr  = {p_addr[1], p_addr[0]};
      rq_wdata = {p_wd[1], p_wd[0]};
      #1;
      if (!busy && pend != 2'b00) begin
        owner = (pend == 2'b11) ? ~mlast : pend[1];
        exp_rdy = owner ? 2'b10 : 2'b01;
        checks++; if (rq_ready !== exp_rdy) begin errors++; $display("FAIL rnd_grant c%0d got %b exp %b", c, rq_ready, exp_rdy); end
        mlast = owner; busy = 1'b1; g_c = c;
        m_addr = p_addr[owner]; m_wd = p_wd[owner]; m_wr = p_wr[owner];
        pend[owner] = 1'b0; outst[owner] = 1'b1;
        m_w  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, 3));
        m_rd = $urandom;
        m_se = ($urandom_range(0, 3) == 0);
        if (m_w < TO) begin
          done_c = g_c + 3 + m_w; exp_err = m_se; exp_rd = m_wr ? 32'h0 : m_rd;
        end else begin
          done_c = g_c + 2 + TO; exp_err = 1'b1; exp_rd = 32'h0;
        end
      end else begin
        checks++; if (rq_ready !== 2'b00) begin errors++; $display("FAIL rnd_no_grant c%0d got %b exp 00", c, rq_ready); end
      end
    end
    rq_valid = 2'b00;
    repeat (12) @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_arbitration();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    test_random(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish exp finish before 300000");
    $fatal(1);
  end

endmodule
